// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
// -----------------------------------------------------------------------------
// Central sequencer for the 5-stage pipeline. Produces the per-cycle stall and
// flush controls for the Fetch/Decode/Execute boundaries (load-use interlock,
// taken-branch squash), holds fetch for a fixed number of cycles after reset,
// and runs the debug halt -> drain -> halted -> resume handshake. Two
// saturating counters record load-use stall cycles and branch flush events.
//
// Ports:
//   clk                pipeline clock, rising edge
//   rst                asynchronous active-low reset
//   rs1_decode         source register 1 of the Decode instruction
//   rs2_decode         source register 2 of the Decode instruction
//   rd_execute         destination register of the Execute instruction
//   load_execute       Execute instruction is a load
//   pc_select_execute  taken branch/jump resolved in Execute
//   halt_req           debug halt request (level)
//   resume_req         debug resume request (level)
//   stall_fetch        hold the PC register
//   stall_decode       hold the Fetch/Decode register
//   flush_decode       clear Fetch/Decode to a bubble
//   flush_execute      clear Decode/Execute to a bubble
//   halt_ack           pipeline empty and halted
//   state_o            0 BOOT, 1 RUN, 2 DRAIN, 3 HALTED
//   stall_count        load-use stall cycles, saturating
//   flush_count        branch flush events, saturating
// -----------------------------------------------------------------------------
module pipeline_control_unit #(
    parameter int BOOT_CYCLES  = 4,   // legal 1..255
    parameter int DRAIN_CYCLES = 3,   // legal 1..15
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_decode,
    input  logic [4:0]       rs2_decode,
    input  logic [4:0]       rd_execute,
    input  logic             load_execute,
    input  logic             pc_select_execute,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             flush_decode,
    output logic             flush_execute,
    output logic             halt_ack,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [7:0]       BOOT_LAST  = 8'(BOOT_CYCLES - 1);
    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state, state_next;
    logic [7:0] boot_cnt, boot_cnt_next;
    logic [3:0] drain_cnt, drain_cnt_next;
    logic       lw_hazard, lw_stall;
    logic       stall_inc, flush_inc;

    // A taken branch outranks the interlock: the Decode instruction is on the
    // wrong path and is about to be squashed, so stalling it is pointless.
    assign lw_hazard = load_execute && (rd_execute != 5'd0) &&
                       ((rd_execute == rs1_decode) || (rd_execute == rs2_decode));
    assign lw_stall  = lw_hazard && !pc_select_execute;

    assign halt_ack = (state == ST_HALTED);
    assign state_o  = state;

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next     = state;
        boot_cnt_next  = boot_cnt;
        drain_cnt_next = drain_cnt;
        stall_fetch    = 1'b1;
        stall_decode   = 1'b1;
        flush_decode   = 1'b1;
        flush_execute  = 1'b1;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        unique case (state)
            ST_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_next    = ST_RUN;
                    boot_cnt_next = 8'd0;
                end else begin
                    boot_cnt_next = boot_cnt + 8'd1;
                end
            end

            ST_RUN: begin
                stall_fetch   = lw_stall;
                stall_decode  = lw_stall;
                flush_decode  = pc_select_execute;
                flush_execute = lw_stall || pc_select_execute;
                stall_inc     = lw_stall;
                flush_inc     = pc_select_execute;
                if (halt_req) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = 4'd0;
                end
            end

            ST_DRAIN: begin
                // A late taken branch must still redirect the PC so that the
                // resume address is the architecturally correct one.
                stall_fetch  = !pc_select_execute;
                stall_decode = 1'b0;
                flush_inc    = pc_select_execute;
                if (drain_cnt == DRAIN_LAST) begin
                    state_next     = ST_HALTED;
                    drain_cnt_next = 4'd0;
                end else begin
                    drain_cnt_next = drain_cnt + 4'd1;
                end
            end

            ST_HALTED: begin
                if (resume_req) begin
                    state_next = ST_RUN;
                end
            end

            default: state_next = ST_BOOT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_BOOT;
            boot_cnt    <= 8'd0;
            drain_cnt   <= 4'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state     <= state_next;
            boot_cnt  <= boot_cnt_next;
            drain_cnt <= drain_cnt_next;
            if (stall_inc && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
            if (flush_inc && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit (CNT_W=4 so saturation is
// reachable quickly). Directed table in RUN, hand-written boot / halt / drain /
// resume / saturation / async-reset sequences, then randomized cycles checked
// against a behavioural model of the specified rules.
module tb_pipeline_control_unit;

    localparam int BOOT_CYCLES  = 4;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_decode, rs2_decode, rd_execute;
    logic             load_execute, pc_select_execute, halt_req, resume_req;
    logic             stall_fetch, stall_decode, flush_decode, flush_execute;
    logic             halt_ack;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_count, flush_count;

    pipeline_control_unit #(
        .BOOT_CYCLES (BOOT_CYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rs1_decode       (rs1_decode),
        .rs2_decode       (rs2_decode),
        .rd_execute       (rd_execute),
        .load_execute     (load_execute),
        .pc_select_execute(pc_select_execute),
        .halt_req         (halt_req),
        .resume_req       (resume_req),
        .stall_fetch      (stall_fetch),
        .stall_decode     (stall_decode),
        .flush_decode     (flush_decode),
        .flush_execute    (flush_execute),
        .halt_ack         (halt_ack),
        .state_o          (state_o),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int m_state, m_boot_elapsed, m_drain_elapsed, m_stall, m_flush;

    typedef struct {
        logic       load;
        logic [4:0] rd, rs1, rs2;
        logic       pc;
        logic       sf, sd, fd, fe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic pc, input logic hr, input logic rr);
        load_execute = ld; rd_execute = rd; rs1_decode = r1; rs2_decode = r2;
        pc_select_execute = pc; halt_req = hr; resume_req = rr;
    endtask

    function automatic bit model_lw_stall();
        bit hz;
        hz = load_execute && (rd_execute != 0) &&
             (rd_execute == rs1_decode || rd_execute == rs2_decode);
        return hz && !pc_select_execute;
    endfunction

    task automatic model_reset();
        m_state = M_BOOT; m_boot_elapsed = 0; m_drain_elapsed = 0;
        m_stall = 0; m_flush = 0;
    endtask

    // Compare every output against what the rules demand for the current
    // model state and the inputs currently driven.
    task automatic check_model();
        bit lws, pc, sf, sd, fd, fe;
        lws = model_lw_stall();
        pc  = pc_select_execute;
        case (m_state)
            M_RUN:   begin sf = lws; sd = lws; fd = pc; fe = lws | pc; end
            M_DRAIN: begin sf = !pc; sd = 0;   fd = 1;  fe = 1;        end
            default: begin sf = 1;   sd = 1;   fd = 1;  fe = 1;        end
        endcase
        check("stall_fetch",   32'(stall_fetch),   32'(sf));
        check("stall_decode",  32'(stall_decode),  32'(sd));
        check("flush_decode",  32'(flush_decode),  32'(fd));
        check("flush_execute", 32'(flush_execute), 32'(fe));
        check("halt_ack",      32'(halt_ack),      32'(m_state == M_HALTED));
        check("state_o",       32'(state_o),       32'(m_state));
        check("stall_count",   32'(stall_count),   32'(m_stall));
        check("flush_count",   32'(flush_count),   32'(m_flush));
    endtask

    // Advance one rising edge and apply the same edge to the model.
    task automatic advance();
        bit lws, pc;
        lws = model_lw_stall();
        pc  = pc_select_execute;
        @(posedge clk);
        case (m_state)
            M_BOOT: begin
                m_boot_elapsed++;
                if (m_boot_elapsed >= BOOT_CYCLES) m_state = M_RUN;
            end
            M_RUN: begin
                if (lws) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
                if (pc)  m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
                if (halt_req) begin m_state = M_DRAIN; m_drain_elapsed = 0; end
            end
            M_DRAIN: begin
                if (pc) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
                m_drain_elapsed++;
                if (m_drain_elapsed == DRAIN_CYCLES) m_state = M_HALTED;
            end
            default: if (resume_req) m_state = M_RUN;
        endcase
        @(negedge clk);
    endtask

    task automatic cycle_checked();
        #1 check_model();
        advance();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 5'd5,  5'd1,  5'd5,  0, 1, 1, 0, 1};
        vecs[1] = '{1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0};
        vecs[2] = '{1, 5'd5,  5'd2,  5'd5,  1, 0, 0, 1, 1};
        vecs[3] = '{0, 5'd5,  5'd5,  5'd5,  0, 0, 0, 0, 0};
        vecs[4] = '{1, 5'd7,  5'd7,  5'd0,  0, 1, 1, 0, 1};
        vecs[5] = '{1, 5'd7,  5'd3,  5'd4,  0, 0, 0, 0, 0};
        vecs[6] = '{0, 5'd0,  5'd0,  5'd0,  1, 0, 0, 1, 1};
        vecs[7] = '{1, 5'd31, 5'd31, 5'd31, 0, 1, 1, 0, 1};

        // ---- Reset and boot hold ----
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        #1 check("reset stall_fetch", 32'(stall_fetch), 32'd1);
        check("reset halt_ack", 32'(halt_ack), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < BOOT_CYCLES; i++) begin
            #1 check("boot stall_fetch", 32'(stall_fetch), 32'd1);
            check("boot state", 32'(state_o), 32'd0);
            check_model();
            advance();
        end
        #1 check("boot done state", 32'(state_o), 32'd1);
        check("boot stall_count", 32'(stall_count), 32'd0);

        // ---- Directed table in RUN ----
        foreach (vecs[i]) begin
            apply(vecs[i].load, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, 0, 0);
            #1 check($sformatf("vec%0d stall_fetch", i),   32'(stall_fetch),   32'(vecs[i].sf));
            check($sformatf("vec%0d stall_decode", i),  32'(stall_decode),  32'(vecs[i].sd));
            check($sformatf("vec%0d flush_decode", i),  32'(flush_decode),  32'(vecs[i].fd));
            check($sformatf("vec%0d flush_execute", i), 32'(flush_execute), 32'(vecs[i].fe));
            check_model();
            advance();
        end
        // Table contributed stalls at vec0,4,7 and flushes at vec2,6.
        #1 check("table stall_count", 32'(stall_count), 32'd3);
        check("table flush_count", 32'(flush_count), 32'd2);

        // ---- Halt / drain / resume ----
        apply(0, 0, 0, 0, 0, 1, 0);
        cycle_checked();
        apply(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            #1 check("drain state", 32'(state_o), 32'd2);
            check("drain halt_ack", 32'(halt_ack), 32'd0);
            cycle_checked();
        end
        #1 check("halted state", 32'(state_o), 32'd3);
        check("halted ack", 32'(halt_ack), 32'd1);
        cycle_checked();
        apply(0, 0, 0, 0, 0, 0, 1);
        cycle_checked();
        apply(0, 0, 0, 0, 0, 0, 0);
        #1 check("resume state", 32'(state_o), 32'd1);
        check("resume ack", 32'(halt_ack), 32'd0);

        // ---- Branch on first DRAIN cycle ----
        apply(0, 0, 0, 0, 0, 1, 0);
        cycle_checked();
        apply(0, 0, 0, 0, 1, 0, 0);
        #1 check("drain branch stall_fetch", 32'(stall_fetch), 32'd0);
        check("drain branch flush_decode", 32'(flush_decode), 32'd1);
        cycle_checked();
        apply(0, 0, 0, 0, 0, 0, 0);
        #1 check("drain after branch stall_fetch", 32'(stall_fetch), 32'd1);
        check("drain branch flush_count", 32'(flush_count), 32'd3);
        repeat (DRAIN_CYCLES - 1) cycle_checked();

        // ---- Resume and halt together: resume wins, then re-drain ----
        apply(0, 0, 0, 0, 0, 1, 1);
        #1 check("halted before both", 32'(state_o), 32'd3);
        cycle_checked();
        #1 check("both -> run", 32'(state_o), 32'd1);
        cycle_checked();
        #1 check("both -> drain", 32'(state_o), 32'd2);
        apply(0, 0, 0, 0, 0, 0, 0);
        repeat (DRAIN_CYCLES) cycle_checked();
        apply(0, 0, 0, 0, 0, 0, 1);
        cycle_checked();

        // ---- Stall counter saturation ----
        for (int i = 0; i < 20; i++) begin
            apply(1, 5'd9, 5'd9, 5'd1, 0, 0, 0);
            cycle_checked();
        end
        apply(0, 0, 0, 0, 0, 0, 0);
        #1 check("stall_count saturated", 32'(stall_count), 32'(CNT_MAX));

        // ---- Randomized cycles against the model ----
        for (int i = 0; i < 600; i++) begin
            apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0));
            cycle_checked();
        end

        // ---- Reach HALTED, then async reset between edges ----
        apply(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20 && m_state != M_HALTED; i++) cycle_checked();
        #1 check("pre-reset halted", 32'(halt_ack), 32'd1);
        #1 rst = 1'b0;
        #1 check("async reset halt_ack", 32'(halt_ack), 32'd0);
        check("async reset state", 32'(state_o), 32'd0);
        check("async reset stall_count", 32'(stall_count), 32'd0);
        check("async reset flush_count", 32'(flush_count), 32'd0);
        check("async reset stall_fetch", 32'(stall_fetch), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 1, 0);
        repeat (BOOT_CYCLES + 2) cycle_checked();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
Central sequencer for the 5-stage pipeline. It generates the per-cycle stall and flush controls for the Fetch/Decode/Execute boundaries: load-use interlock and taken-branch squash. It also owns a post-reset boot hold and a debug halt/drain/resume handshake. Saturating event counters support performance bring-up.

Parameters:
BOOT_CYCLES, 4, cycles fetch is held after reset release (legal 1..255)
DRAIN_CYCLES, 3, cycles needed to empty Execute/Memory/Writeback on halt (legal 1..15)
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-low reset; state cleared while rst==0
rs1_decode  input  5  source register 1 of instruction in Decode
rs2_decode  input  5  source register 2 of instruction in Decode
rd_execute  input  5  destination register of instruction in Execute
load_execute  input  1  instruction in Execute is a load (result from data memory)
pc_select_execute  input  1  taken branch/jump resolved in Execute
halt_req  input  1  debug halt request (level)
resume_req  input  1  debug resume request (level)
stall_fetch  output  1  hold the PC register
stall_decode  output  1  hold the Fetch/Decode register
flush_decode  output  1  clear the Fetch/Decode register to a bubble
flush_execute  output  1  clear the Decode/Execute register to a bubble
halt_ack  output  1  pipeline empty and halted
state_o  output  2  current state: 0 BOOT, 1 RUN, 2 DRAIN, 3 HALTED
stall_count  output  CNT_W  load-use stall cycles, saturating
flush_count  output  CNT_W  branch flush events, saturating

Behaviour:
- Reset (rst==0, asynchronous): state=BOOT, boot/drain counters=0, stall_count=0, flush_count=0.
- Reset outputs: stall_fetch=stall_decode=flush_decode=flush_execute=1, halt_ack=0, state_o=0.
- Stall/flush outputs are combinational from state and inputs, in the same cycle. halt_ack and state_o decode directly from the state register.
- BOOT:
  - All four stall/flush outputs are 1.
  - The boot counter increments on each clk edge after rst goes high.
  - When the counter reaches BOOT_CYCLES-1, the next state is RUN, so exactly BOOT_CYCLES held cycles occur after release.
- RUN:
  - lw_hazard = load_execute & (rd_execute!=0) & (rd_execute==rs1_decode | rd_execute==rs2_decode).
  - lw_stall = lw_hazard & ~pc_select_execute. A taken branch has priority because the Decode instruction is wrong-path.
  - stall_fetch = stall_decode = lw_stall.
  - flush_decode = pc_select_execute.
  - flush_execute = lw_stall | pc_select_execute.
  - If halt_req=1, the next state is DRAIN. This cycle's outputs remain the RUN equations.
- DRAIN:
  - stall_fetch = ~pc_select_execute, so a late taken branch still updates the PC and the correct resume PC is preserved.
  - stall_decode=0, flush_decode=1, flush_execute=1.
  - The drain counter counts DRAIN_CYCLES cycles, then the next state is HALTED.
  - Deasserting halt_req during DRAIN does not abort the drain.
- HALTED:
  - stall_fetch=1, stall_decode=1, flush_decode=1, flush_execute=1, halt_ack=1.
  - If resume_req=1, the next state is RUN and halt_ack drops on that edge.
  - If resume_req and halt_req are both 1, resume wins. RUN then re-enters DRAIN on the following cycle if halt_req is still high.
- resume_req is ignored outside HALTED. halt_req is ignored in BOOT.
- Counters:
  - stall_count increments on every clk edge where state==RUN and lw_stall==1.
  - flush_count increments on every edge where state is RUN or DRAIN and pc_select_execute==1.
  - Both hold at 2^CNT_W-1 and never wrap.
- Reset asserted mid-DRAIN or mid-HALTED returns immediately to BOOT, with halt_ack=0 asynchronously.

Test Plan:
1. Boot hold:
   - Stimulus: rst=0 for 3 cycles, release.
   - Response: stall_fetch=1 for exactly 4 rising edges after release; state_o=1 on the 5th; stall_count=0.
2. Load-use interlock:
   - Stimulus: RUN, load_execute=1, rd_execute=5, rs2_decode=5 for 1 cycle.
   - Response: stall_fetch=stall_decode=flush_execute=1, flush_decode=0; stall_count increments to 1.
   - Stimulus: repeat with rd_execute=0.
   - Response: no stall.
3. Branch priority:
   - Stimulus: RUN, load-use hazard and pc_select_execute=1 in the same cycle.
   - Response: stall_fetch=0, flush_decode=1, flush_execute=1; flush_count=1; stall_count unchanged.
4. Halt/drain/resume:
   - Stimulus: halt_req=1 for 1 cycle in RUN.
   - Response: state_o=2 for 3 cycles, then 3; halt_ack=1.
   - Stimulus: resume_req=1.
   - Response: state_o=1 next edge, halt_ack=0.
5. Branch during drain:
   - Stimulus: pc_select_execute=1 on the first DRAIN cycle.
   - Response: stall_fetch=0 that cycle only; flush_decode=1; flush_count increments.
6. Saturation and async reset:
   - Stimulus: CNT_W=4 build, 20 consecutive load-use stalls.
   - Response: stall_count=15.
   - Stimulus: drop rst mid-HALTED, between clock edges.
   - Response: halt_ack=0, state_o=0, counters=0 immediately.
